// File: rtl/quad_decoder.sv
// quad_decoder: quadrature decoder with step/dir pulses, wrap-around position and illegal-transition count.
// Optional per-phase glitch filter is compiled in with QDEC_GLITCH_FILTER_EN.
module quad_decoder #(
   parameter int WIDTH      = 16,
   parameter int FILTER_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             quad_a,
   input  logic             quad_b,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_err,
   output logic             step,
   output logic             dir,
   output logic [WIDTH-1:0] position,
   output logic             err,
   output logic [7:0]       err_cnt
);
   localparam logic [WIDTH-1:0] ONE = 1;
   if (WIDTH < 2 || FILTER_LEN < 1) begin : g_bad_param
      $error("quad_decoder: WIDTH must be >= 2 and FILTER_LEN >= 1");
   end
   logic [1:0]       s1_q, s2_q, warm_q, prev_q, cur, chg;
   logic             primed_q, primed_d, step_q, step_d, dir_q, dir_d, err_q, err_d;
   logic             legal, illegal, up;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [7:0]       cnt_q, cnt_d;
   // warm_q delays priming until the synchronizer holds real input levels
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_q   <= 2'b00;
         s2_q   <= 2'b00;
         warm_q <= 2'b00;
      end else begin
         s1_q   <= {quad_a, quad_b};
         s2_q   <= s1_q;
         warm_q <= {warm_q[0], 1'b1};
      end
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0]    f_q;
   logic [CW-1:0] fc_q [2];
   // Filter is seeded straight from the synchronizer until the decoder primes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         f_q   <= 2'b00;
         fc_q  <= '{default: '0};
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!primed_q || s2_q[k] == f_q[k] || fc_q[k] == CW'(FILTER_LEN - 1)) begin
               fc_q[k] <= '0;
               f_q[k]  <= s2_q[k];
            end else begin
               fc_q[k] <= fc_q[k] + CW'(1);
            end
         end
      end
   assign cur = f_q;
`else
   assign cur = s2_q;
`endif
   assign chg     = cur ^ prev_q;
   assign legal   = primed_q && ^chg;
   assign illegal = primed_q && &chg;
   assign up      = prev_q[0] ^ cur[1];
   always_comb begin
      primed_d = primed_q | warm_q[1];
      step_d   = legal;
      dir_d    = legal ? up : dir_q;
      pos_d    = load ? load_val : legal ? (up ? pos_q + ONE : pos_q - ONE) : pos_q;
      err_d    = illegal | (err_q & ~clr_err);
      cnt_d    = illegal ? (clr_err ? 8'd1 : (&cnt_q ? cnt_q : cnt_q + 8'd1)) : clr_err ? 8'd0 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         primed_q <= 1'b0;
         prev_q   <= 2'b00;
         step_q   <= 1'b0;
         dir_q    <= 1'b1;
         pos_q    <= '0;
         err_q    <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         primed_q <= primed_d;
         prev_q   <= primed_q ? cur : s2_q;
         step_q   <= step_d;
         dir_q    <= dir_d;
         pos_q    <= pos_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   assign step     = step_q;
   assign dir      = dir_q;
   assign position = pos_q;
   assign err      = err_q;
   assign err_cnt  = cnt_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed and randomized checks of quad_decoder against a Gray-code reference model.
module tb_quad_decoder;
   localparam int W  = 16;
   localparam int FL = 3;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int L = FL;
`else
   localparam int L = 0;
`endif
   localparam int D = 2 + L;
   logic          clk = 1'b0, rst_n = 1'b0, quad_a = 1'b1, quad_b = 1'b1, load = 1'b0, clr_err = 1'b0;
   logic [W-1:0]  load_val = '0;
   logic          step, dir, err;
   logic [W-1:0]  position;
   logic [7:0]    err_cnt;
   int            tests = 0, fails = 0, step_seen = 0;
   bit            chk_en = 1'b1;
   quad_decoder #(.WIDTH(W), .FILTER_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .load(load),
      .load_val(load_val), .clr_err(clr_err), .step(step), .dir(dir),
      .position(position), .err(err), .err_cnt(err_cnt)
   );
   always #5 clk = ~clk;
   // Reference model: position of each phase pair along the up cycle 00,10,11,01
   int           gi [4] = '{0, 3, 1, 2};
   int           n;
   logic [1:0]   hist [$];
   logic [W-1:0] m_pos;
   bit           m_step, m_dir, m_err;
   int           m_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; hist.delete();
         m_pos = '0; m_step = 0; m_dir = 1; m_err = 0; m_cnt = 0;
      end else begin
         int ic, ip, d;
         n++;
         hist.push_front({quad_a, quad_b});
         if (hist.size() > 16) void'(hist.pop_back());
         d = 0;
         if (n >= 4) begin
            ic = (n - D < 1) ? 1 : n - D;
            ip = (n - D - 1 < 1) ? 1 : n - D - 1;
            d = (gi[hist[n - ic]] - gi[hist[n - ip]] + 4) % 4;
         end
         m_step = (d == 1 || d == 3);
         if (m_step) m_dir = (d == 1);
         if (load) m_pos = load_val;
         else if (d == 1) m_pos = m_pos + 1'b1;
         else if (d == 3) m_pos = m_pos - 1'b1;
         if (d == 2) begin
            m_err = 1;
            m_cnt = clr_err ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
         end else if (clr_err) begin
            m_err = 0; m_cnt = 0;
         end
      end
   end
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (step) step_seen++;
         if (chk_en) begin
            tests++;
            if (step !== m_step || dir !== m_dir || position !== m_pos || err !== m_err || err_cnt !== 8'(m_cnt)) begin
               fails++;
               $display("FAIL model t=%0t got step=%b dir=%b pos=%h err=%b cnt=%0d exp step=%b dir=%b pos=%h err=%b cnt=%0d",
                        $time, step, dir, position, err, err_cnt, m_step, m_dir, m_pos, m_err, m_cnt);
            end
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask
   task automatic drv(input logic [1:0] ab, input int hold);
      {quad_a, quad_b} = ab;
      repeat (hold) @(negedge clk);
   endtask
   task automatic pulse_load(input logic [W-1:0] v);
      load = 1'b1; load_val = v;
      @(negedge clk);
      load = 1'b0;
   endtask
   task automatic chk_reset_vals(input string nm);
      chk({nm, "_step"}, 32'(step), 0);
      chk({nm, "_dir"}, 32'(dir), 1);
      chk({nm, "_pos"}, 32'(position), 0);
      chk({nm, "_err"}, 32'(err), 0);
      chk({nm, "_cnt"}, 32'(err_cnt), 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      int base, lat;
      bit got;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("prime_steps", 32'(step_seen), 0);
      chk("prime_err", 32'(err), 0);
      chk("prime_pos", 32'(position), 0);
      drv(2'b10, 8); drv(2'b00, 8);
      chk("down2_pos", 32'(position), 32'hFFFE);
      pulse_load(16'h0000);
      base = step_seen;
      drv(2'b10, 8); drv(2'b11, 8); drv(2'b01, 8); drv(2'b00, 8);
      chk("up4_steps", 32'(step_seen - base), 4);
      chk("up4_dir", 32'(dir), 1);
      chk("up4_pos", 32'(position), 4);
      drv(2'b01, 8);
      chk("down_dir", 32'(dir), 0);
      chk("down_pos", 32'(position), 3);
      pulse_load(16'hFFFF);
      drv(2'b00, 8);
      chk("wrap_up", 32'(position), 0);
      drv(2'b01, 8);
      chk("wrap_down", 32'(position), 32'hFFFF);
      drv(2'b00, 8);
      base = step_seen;
      drv(2'b11, 8);
      chk("jump_err", 32'(err), 1);
      chk("jump_cnt", 32'(err_cnt), 1);
      chk("jump_nostep", 32'(step_seen - base), 0);
      chk("jump_pos", 32'(position), 0);
      chk("jump_dir", 32'(dir), 1);
      drv(2'b00, D);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("setwins_err", 32'(err), 1);
      chk("setwins_cnt", 32'(err_cnt), 1);
      repeat (6) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err", 32'(err), 0);
      chk("clr_cnt", 32'(err_cnt), 0);
      for (int i = 0; i < 270; i++) drv(i % 2 == 0 ? 2'b11 : 2'b00, L + 2);
      repeat (D + 2) @(negedge clk);
      chk("sat_cnt", 32'(err_cnt), 255);
      chk("sat_err", 32'(err), 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      pulse_load(16'h0000);
      {quad_a, quad_b} = 2'b10;
      got = 0; lat = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
         @(posedge clk); #1;
         if (step) begin got = 1; lat = c; end
      end
      @(negedge clk);
      chk("latency", 32'(lat), D + 1);
      chk("latency_pos", 32'(position), 1);
      repeat (8) @(negedge clk);
      for (int s = 0; s < 300; s++) begin
         int hold;
         {quad_a, quad_b} = 2'($urandom_range(0, 3));
         hold = $urandom_range(L + 1, L + 4);
         for (int c = 0; c < hold; c++) begin
            load = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom);
            clr_err = ($urandom_range(0, 31) == 0);
            @(negedge clk);
         end
      end
      load = 1'b0; clr_err = 1'b0;
      repeat (8) @(negedge clk);
      pulse_load(16'd7);
      repeat (4) @(negedge clk);
      chk("pre_rst_pos", 32'(position), 7);
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      repeat (3) @(negedge clk);
      {quad_a, quad_b} = 2'b10;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rerst_pos", 32'(position), 0);
      drv(2'b11, 8);
      chk("rerst_step_pos", 32'(position), 1);
      chk("rerst_step_dir", 32'(dir), 1);
`ifdef QDEC_GLITCH_FILTER_EN
      chk_en = 1'b0;
      base = step_seen;
      drv(2'b01, 2);
      drv(2'b11, 20);
      chk("glitch_reject", 32'(step_seen - base), 0);
      chk("glitch_pos", 32'(position), 1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature input decoder. Samples two asynchronous encoder phases, decodes Gray-code transitions into single-cycle step pulses with direction, and keeps a loadable wrap-around position count. It sits on the input side of the counter datapath and produces the direction/enable stimulus that a position counter consumes. It also flags and counts illegal double-phase transitions.

## Interface
- `WIDTH`, 16, position counter width (≥ 2)
- `FILTER_LEN`, 3, consecutive stable cycles required by the glitch filter (≥ 1; used only when the filter is compiled in)

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `quad_a` in 1: encoder phase A, asynchronous to `clk`
- `quad_b` in 1: encoder phase B, asynchronous to `clk`
- `load` in 1: synchronous position load
- `load_val` in WIDTH: value written to `position` on `load`
- `clr_err` in 1: clears `err` and `err_cnt`
- `step` out 1: one-cycle pulse per decoded legal transition
- `dir` out 1: direction of the last legal transition (1 = up, 0 = down)
- `position` out WIDTH: current position
- `err` out 1: sticky illegal-transition flag
- `err_cnt` out 8: saturating illegal-transition count

## Operation
- Synchronizer: each phase passes through a 2-flop synchronizer. Output is `sa`/`sb`.
- Filter: produces `fa`/`fb`. See Configuration.
- Prime: after reset, a `primed` flag is 0. On the first cycle, `prev` is loaded from `{fa,fb}` and `primed` is set. No step and no error occur on that cycle.
- Decode (primed): compare `cur={fa,fb}` against `prev` every cycle, then set `prev` to `cur`.
  - Up sequence: 00→10→11→01→00 (A leads). Result: `step`=1, `dir`=1, `position`+1.
  - Down sequence: 00→01→11→10→00. Result: `step`=1, `dir`=0, `position`−1.
  - No change: no action.
  - Both bits changed (00↔11, 01↔10): illegal. `err` is set, `err_cnt` increments and saturates at 255. No step. `dir` and `position` are unchanged.
- Position arithmetic is modulo 2^WIDTH:
  - all-ones + 1 = 0
  - 0 − 1 = all-ones
- Priority on `position`: reset, then `load`, then step. If `load` and a legal step occur in the same cycle:
  - `position` takes `load_val`.
  - `step` still pulses and `dir` still updates.
- `clr_err`:
  - Alone: next cycle `err`=0 and `err_cnt`=0.
  - Same cycle as an illegal transition: set wins. Result is `err`=1, `err_cnt`=1.
- `dir` holds its value between steps.

## Timing
- Reset values: `step`=0, `dir`=1, `position`=0, `err`=0, `err_cnt`=0. Internal state also resets: `primed`=0, `prev`=00, synchronizer flops 0, filter state cleared.
- Reset is fully asynchronous. Asserting it mid-motion discards all state. After release, the block re-primes on the current input level, so no spurious step or error is produced.
- Latency without the filter: an input change stable before clock edge N produces `step` and the updated `position` after edge N+2. That is 2 synchronizer stages plus 1 decode register.
- Latency with the filter: add FILTER_LEN cycles to the figure above.
- All outputs are registered. `step` is high for exactly one cycle per legal transition.
- Maximum decodable rate:
  - Without the filter: one transition per clock.
  - With the filter: one transition per FILTER_LEN+1 clocks.
  - A faster input may merge two transitions into one apparent double change, which is reported as an illegal transition.
- `load` and `clr_err` take effect at the next rising edge and are visible on outputs in the following cycle.

## Configuration
- Macro: `QDEC_GLITCH_FILTER_EN`.
- Defined: each phase has its own counter.
  - `fa` updates to `sa` only after `sa` has differed from `fa` for FILTER_LEN consecutive cycles.
  - Any cycle with `sa == fa` resets that phase's counter.
  - Pulses shorter than FILTER_LEN cycles are rejected.
  - The same rules apply to `fb`/`sb`.
- Undefined: `fa=sa` and `fb=sb` directly. FILTER_LEN is ignored. No filter logic is synthesized.

## Test plan
- Reset release with A=1, B=1, then hold 20 cycles → `step` never pulses, `err`=0, `position`=0.
- Four up steps (00→10→11→01→00), each held 8 cycles → 4 `step` pulses, `dir`=1, `position`=4. Then one down step (00→01) → `dir`=0, `position`=3.
- `load` with `load_val`=0xFFFF and WIDTH=16, then one up step → `position`=0x0000 (wrap). From 0x0000, one down step → `position`=0xFFFF.
- Jump 00→11 → `err`=1, `err_cnt`=1, no `step`, `position` unchanged. Then assert `clr_err` in the same cycle as a 11→00 jump → `err`=1, `err_cnt`=1.
- With `QDEC_GLITCH_FILTER_EN` and FILTER_LEN=3:
  - A 2-cycle pulse on A → no step.
  - A 3-cycle level change → one `step`, arriving 3 cycles later than it does with the filter compiled out.
- Assert `rst_n` low mid-sequence with `position`=7 → all outputs return to their reset values immediately. After release, the first transition yields `position`=±1.
